// File: rtl/pipe_hazard_ctrl.sv
// Purpose : stall/flush sequencer for the 5-stage pipeline. Handles load-use
//           hazards, taken-branch squashes and variable-latency data-memory
//           accesses, and keeps stall/flush perf counters and a sticky
//           memory-timeout flag.
// Latency : enables, flushes, bubble and dmem_req are combinational from the
//           current state and inputs. State, wait counter, counters and
//           mem_err update on the rising clk edge.
// Backpressure: an unacknowledged data-memory access (dmem_req high, dmem_ack
//           low) freezes PC, IF/ID, ID/EX and EX/MEM. MEM/WB keeps advancing
//           with a bubble so the stalled access never writes back twice.
// Ports   :
//   clk, rst_n        clock, synchronous active-low reset
//   id_rs, id_rt      source registers of the ID instruction
//   id_uses_rt        ID instruction reads rt
//   ex_mem_read       EX instruction is a load
//   ex_rd             EX destination register
//   ex_branch_taken   branch resolved taken in EX
//   mem_access        MEM instruction is a load/store
//   dmem_req/ack      data-memory handshake
//   *_en              pipeline register write enables
//   if_id_flush       load NOP into IF/ID
//   id_ex_flush       bubble into ID/EX
//   mem_wb_bubble     zero the write controls entering MEM/WB
//   mem_err           sticky memory timeout flag
//   stall_cnt         saturating count of stall cycles
//   flush_cnt         saturating count of branch flushes
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0]      TIMEOUT = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;
    logic        stall_inc;
    logic        flush_inc;
    logic        err_set;
    logic        load_use;
    logic        ack_eff;

    // r0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // An ack only counts while a request is actually outstanding.
    assign ack_eff = mem_access && dmem_ack;

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        err_set       = 1'b0;
        dmem_req      = mem_access;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;

        unique case (state)
            RUN: begin
                if (mem_access && !ack_eff) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    stall_inc     = 1'b1;
                    state_nxt     = MEM_WAIT;
                end else if (ex_branch_taken) begin
                    // The load-use dependent sits in ID and is squashed here,
                    // so no stall is needed on top of the flush.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, push a bubble into EX. The bubble
                    // clears ex_mem_read next cycle, ending the stall.
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!ack_eff) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    stall_inc     = 1'b1;
                    if (wait_cnt < TIMEOUT) begin
                        wait_cnt_nxt = wait_cnt + 16'd1;
                    end
                    // Flag only; the controller keeps waiting for the ack.
                    err_set = (wait_cnt_nxt >= TIMEOUT);
                end else begin
                    // Release cycle: branch/load-use get re-evaluated in RUN.
                    state_nxt    = RUN;
                    wait_cnt_nxt = 16'd0;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // During reset every register loads, fed with NOP/bubble controls,
        // so the pipe drains to a clean state; no memory request goes out.
        if (!rst_n) begin
            dmem_req      = 1'b0;
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            id_ex_en      = 1'b1;
            ex_mem_en     = 1'b1;
            mem_wb_en     = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= 16'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
            if (err_set) begin
                mem_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the write enables of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and inserts bubbles by squashing stage control fields. It resolves three conditions:

- load-use hazards;
- taken-branch squashes;
- variable-latency data-memory accesses, via a req/ack handshake.

It also keeps stall/flush performance counters and a sticky memory-timeout flag.

## Interface
Parameters:
- MEM_TIMEOUT, 255 — MEM_WAIT cycle count at which mem_err sets (1..65535).
- CNT_W, 16 — width of the stall/flush counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_access  in  1  instruction in MEM is a load or store.
- dmem_ack  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data memory access request.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register write enables.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  zero the ID/EX control fields (bubble).
- mem_wb_bubble  out  1  zero the 2-bit write-control field entering MEM/WB.
- mem_err  out  1  sticky memory timeout flag.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of branch flushes.

## Operation
- FSM states: RUN and MEM_WAIT. State, wait counter, mem_err and the perf counters are registered. The enable, flush, bubble and dmem_req outputs are combinational from state and the current inputs.
- load_use = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
- Priority in RUN: memory stall > branch flush > load-use > normal.
- dmem_req = mem_access in both states. It is held high until the cycle dmem_ack=1.

RUN cases:
- **Memory stall** (mem_access & !dmem_ack):
  - pc/if_id/id_ex/ex_mem enables = 0; mem_wb_en = 1; mem_wb_bubble = 1.
  - Next state MEM_WAIT; stall_cnt += 1.
- **Memory completes same cycle** (mem_access & dmem_ack): zero-wait access; evaluate the remaining priorities as if no memory stall.
- **Branch flush** (ex_branch_taken):
  - All enables = 1; if_id_flush = 1; id_ex_flush = 1; flush_cnt += 1.
  - Any load_use in the same cycle is ignored, because the dependent instruction is squashed.
- **Load-use stall**:
  - pc_en = 0, if_id_en = 0, id_ex_en = 1 with id_ex_flush = 1; ex_mem_en = 1; mem_wb_en = 1.
  - stall_cnt += 1. This is a single-cycle stall: the bubble clears ex_mem_read next cycle.
- **Normal**: all enables = 1; all flush/bubble outputs = 0.

MEM_WAIT cases:
- **dmem_ack = 0**:
  - Same outputs as the memory-stall cycle; stall_cnt += 1; wait_cnt += 1.
  - If wait_cnt reaches MEM_TIMEOUT, mem_err := 1. The controller keeps waiting; there is no abort.
- **dmem_ack = 1**:
  - All enables = 1; flushes and bubble = 0; next state RUN; wait_cnt := 0.
  - ex_branch_taken and load_use are ignored this cycle and re-evaluated in RUN on the following cycle.
- ex_branch_taken and load_use have no effect while in MEM_WAIT.

Other rules:
- Counters saturate at 2^CNT_W−1 and never wrap. mem_err clears only on reset.
- wait_cnt is 16 bits and saturates at MEM_TIMEOUT.

## Timing
- Reset (clk edge with rst_n=0):
  - state := RUN; wait_cnt, stall_cnt, flush_cnt, mem_err := 0.
  - While rst_n=0, outputs are forced: all enables = 1, if_id_flush = id_ex_flush = mem_wb_bubble = 1, dmem_req = 0. This clears the pipe to NOPs.
- Reset asserted mid-MEM_WAIT: the controller is in RUN on the first cycle after rst_n rises, and the pending request is dropped.
- Control outputs have zero latency from the inputs. State and counter changes are visible one cycle after the triggering edge.
- A load-use stall lasts exactly 1 cycle. A branch flush lasts exactly 1 cycle. A memory stall lasts N cycles for ack arriving N cycles after the first request cycle.
- dmem_ack is sampled only while dmem_req = 1. An ack with mem_access = 0 is ignored.

## Test plan
- **Load-use:** ex_mem_read=1, ex_rd=5, id_rs=5 → exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, then all enables 1; stall_cnt=1. Repeat with ex_rd=0 → no stall.
- **Branch + load-use same cycle:** ex_branch_taken=1 with a load_use match → if_id_flush=id_ex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- **Memory wait:** mem_access=1, ack after 3 cycles → dmem_req high 4 cycles, pc/if_id/id_ex/ex_mem enables 0 for 3 cycles, mem_wb_bubble=1 for 3 cycles, stall_cnt=3, state back to RUN; zero-wait ack → no stall.
- **Timeout:** MEM_TIMEOUT=4, ack withheld 10 cycles → mem_err=1 after the 4th MEM_WAIT cycle, still stalled; ack releases; mem_err stays 1 until rst_n=0.
- **Reset mid-wait:** rst_n=0 during MEM_WAIT → next cycle state RUN, counters 0, mem_err 0, flush outputs 1 while rst_n=0.
- **Saturation:** CNT_W=4, 20 consecutive load-use stalls → stall_cnt holds at 15.
